serial_adder: RTL and testbench

//  Parametrised bit-serial adder/subtractor, successor to the single-bit full adder.
//  - Reuses one full-adder cell over WIDTH cycles, LSB first, with a registered carry.
//  - start/busy/done handshake; result held stable until the next operation completes.
//  - Adds subtract mode and a signed-overflow flag.

---
 rtl/serial_adder_if.sv | 15 +
 rtl/serial_adder.sv | 66 ++++++
 tb/tb_serial_adder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake and operand/result bus for serial_adder (start, A, B, Cin, sub in; S, Cout, ovf, busy, done out)
interface serial_adder_if #(parameter int WIDTH = 8) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             ovf;
  logic             busy;
  logic             done;
  modport master (output start, A, B, Cin, sub, input S, Cout, ovf, busy, done);
  modport slave (input start, A, B, Cin, sub, output S, Cout, ovf, busy, done);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial add/subtract over WIDTH cycles; ports clk, rst (sync active-high), bus (slave: start/A/B/Cin/sub in, S/Cout/ovf/busy/done out)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a, b, sum;
  logic [CW-1:0] cnt;
  logic c, cmsb, bit_s, carry;
  assign bit_s = a[0] ^ b[0] ^ c;
  assign carry = (a[0] & b[0]) | (a[0] & c) | (b[0] & c);
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      sum      <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      cmsb     <= 1'b0;
      bus.S    <= '0;
      bus.Cout <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          a        <= bus.A;
          b        <= bus.sub ? ~bus.B : bus.B;
          c        <= bus.sub | bus.Cin;
          cnt      <= '0;
          bus.busy <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          sum <= (sum >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
          a   <= a >> 1;
          b   <= b >> 1;
          c   <= carry;
          cnt <= cnt + CW'(1);
          // the carry entering the last bit is the carry into the MSB
          if (cnt == CW'(WIDTH - 1)) begin
            cmsb  <= c;
            state <= DONE;
          end
        end
        DONE: begin
          bus.S    <= sum;
          bus.Cout <= c;
          bus.ovf  <= cmsb ^ c;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder, directed WIDTH=8 vectors plus exhaustive WIDTH=4 and WIDTH=1 sweeps
module tb_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  bit fin [2];
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic int model(int w, int a, int b, int cin, int sb);
    int m, bb, ce, full, low, co, cm;
    m = (1 << w) - 1;
    bb = sb != 0 ? (~b) & m : b;
    ce = sb != 0 ? 1 : cin;
    full = a + bb + ce;
    low = (a & (m >> 1)) + (bb & (m >> 1)) + ce;
    co = (full >> w) & 1;
    cm = (low >> (w - 1)) & 1;
    return (co << (w + 1)) | ((cm ^ co) << w) | (full & m);
  endfunction
  serial_adder_if #(8) m ();
  logic rst8;
  serial_adder #(.WIDTH(8)) dut (.clk(clk), .rst(rst8), .bus(m));
  int q8[$];
  always @(negedge clk) begin
    int e;
    if (m.done === 1'b1) begin
      if (q8.size() == 0) chk("unexpected_done8", 1, 0);
      else begin
        e = q8.pop_front();
        chk("result8", {m.Cout, m.ovf, m.S}, e);
      end
    end
  end
  task automatic go8(logic [7:0] a, logic [7:0] b, logic cin, logic sb, bit push, int exp);
    int t = 0;
    while (m.busy !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("idle_timeout", t, 0);
    m.A = a;
    m.B = b;
    m.Cin = cin;
    m.sub = sb;
    m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    m.A = 8'h5A;
    m.B = 8'hA5;
    if (push) q8.push_back(exp);
  endtask
  task automatic wait8(output int lat, output int bc);
    lat = 0;
    bc = 0;
    while (m.done !== 1'b1 && lat < 100) begin
      if (m.busy === 1'b1) bc++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) chk("done_timeout", lat, 0);
  endtask
  for (genvar g = 0; g < 2; g++) begin : sw
    localparam int W = g == 0 ? 4 : 1;
    serial_adder_if #(W) s ();
    logic r;
    serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(r), .bus(s));
    int q[$];
    always @(negedge clk) begin
      int e;
      if (s.done === 1'b1) begin
        if (q.size() == 0) chk($sformatf("unexpected_done_w%0d", W), 1, 0);
        else begin
          e = q.pop_front();
          chk($sformatf("sweep_w%0d", W), {s.Cout, s.ovf, s.S}, e);
        end
      end
    end
    initial begin
      int t;
      s.start = 1'b0;
      s.A = '0;
      s.B = '0;
      s.Cin = 1'b0;
      s.sub = 1'b0;
      r = 1'b1;
      repeat (2) @(negedge clk);
      r = 1'b0;
      for (int a = 0; a < (1 << W); a++)
        for (int b = 0; b < (1 << W); b++)
          for (int ci = 0; ci < 2; ci++)
            for (int sb = 0; sb < 2; sb++) begin
              s.A = W'(a);
              s.B = W'(b);
              s.Cin = ci[0];
              s.sub = sb[0];
              s.start = 1'b1;
              @(negedge clk);
              s.start = 1'b0;
              q.push_back(model(W, a, b, ci, sb));
              t = 0;
              while (s.done !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
              end
              if (t >= 20) chk($sformatf("sweep_timeout_w%0d", W), t, 0);
            end
      fin[g] = 1'b1;
    end
  end
  initial begin
    int lat, bc, nd, t;
    m.start = 1'b0;
    m.A = '0;
    m.B = '0;
    m.Cin = 1'b0;
    m.sub = 1'b0;
    rst8 = 1'b1;
    @(negedge clk);
    m.start = 1'b1;
    m.A = 8'hFF;
    m.B = 8'h01;
    @(negedge clk);
    chk("rst_S", m.S, 0);
    chk("rst_Cout", m.Cout, 0);
    chk("rst_ovf", m.ovf, 0);
    chk("rst_busy", m.busy, 0);
    chk("rst_done", m.done, 0);
    rst8 = 1'b0;
    m.start = 1'b0;
    @(negedge clk);
    chk("rst_start_idle", m.busy, 0);
    go8(8'hFF, 8'h01, 1'b0, 1'b0, 1, 'h200);
    wait8(lat, bc);
    chk("latency", lat, 9);
    chk("busy_cycles", bc, 9);
    chk("busy_at_done", m.busy, 0);
    go8(8'h7F, 8'h01, 1'b0, 1'b0, 1, 'h180);
    wait8(lat, bc);
    go8(8'h00, 8'h00, 1'b1, 1'b0, 1, 'h001);
    wait8(lat, bc);
    go8(8'h05, 8'h07, 1'b1, 1'b1, 1, 'h0FE);
    wait8(lat, bc);
    go8(8'h80, 8'h01, 1'b0, 1'b1, 1, 'h37F);
    wait8(lat, bc);
    go8(8'h10, 8'h20, 1'b0, 1'b0, 1, 'h030);
    repeat (3) @(negedge clk);
    m.A = 8'h11;
    m.B = 8'h22;
    m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    chk("S_hold_midrun", m.S, 'h7F);
    wait8(lat, bc);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      nd += int'(m.done);
    end
    chk("extra_done", nd, 0);
    chk("S_held_after", m.S, 'h30);
    go8(8'h0F, 8'h01, 1'b0, 1'b0, 0, 0);
    repeat (4) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    chk("abort_busy", m.busy, 0);
    chk("abort_S", m.S, 0);
    chk("abort_Cout", m.Cout, 0);
    chk("abort_ovf", m.ovf, 0);
    chk("abort_done", m.done, 0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      nd += int'(m.done);
    end
    chk("abort_no_done", nd, 0);
    go8(8'h03, 8'h04, 1'b0, 1'b0, 1, 'h007);
    wait8(lat, bc);
    chk("latency_after_abort", lat, 9);
    t = 0;
    while (!(fin[0] && fin[1]) && t < 50000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50000) chk("sweep_finish_timeout", t, 0);
    @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", sw[0].q.size(), 0);
    chk("q1_drained", sw[1].q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
